// File: rtl/cc_cond_unit.sv
// rtl/cc_cond_unit.sv - Y86-64 condition-code register and jXX/cmovXX condition evaluator
module cc_cond_unit #(
  parameter bit BYPASS = 1'b0,
  parameter int WIDTH  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_cc,
  input  logic             cc_hold,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  input  logic [3:0]       ifun,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic             cnd,
  output logic             ifun_bad,
  output logic             cc_upd
);

  // A non-AOK status must never let an instruction's flags land, even on OPq.
  logic upd;
  assign upd = set_cc & ~cc_hold;

  // Effective flags seen by the condition logic.
  logic ezf, esf, eof;

  // CC register: reset leaves ZF set so "e" is true before any OPq retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf     <= 1'b1;
      sf     <= 1'b0;
      of     <= 1'b0;
      cc_upd <= 1'b0;
    end else begin
      cc_upd <= upd;
      if (upd) begin
        zf <= alu_zero;
        sf <= alu_res[WIDTH-1];
        of <= alu_overflow;
      end
    end
  end

  // Flag source: the bypass lets a same-cycle OPq feed the branch decision.
  always_comb begin
    ezf = zf;
    esf = sf;
    eof = of;
    if (BYPASS && upd) begin
      ezf = alu_zero;
      esf = alu_res[WIDTH-1];
      eof = alu_overflow;
    end
  end

  // Condition table; codes above 6 are undefined and never taken.
  always_comb begin
    cnd      = 1'b0;
    ifun_bad = 1'b0;
    case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (esf ^ eof) | ezf;
      4'd2:    cnd = esf ^ eof;
      4'd3:    cnd = ezf;
      4'd4:    cnd = ~ezf;
      4'd5:    cnd = ~(esf ^ eof);
      4'd6:    cnd = ~(esf ^ eof) & ~ezf;
      default: ifun_bad = 1'b1;
    endcase
  end

endmodule

// File: doc/cc_cond_unit.md
Name: cc_cond_unit

Overview:
- Consumer end of the 64-bit ALU result interface (ADD/SUB/AND/XOR producing res, overflow, zero).
- Captures ALU status into the Y86-64 condition-code register (ZF, SF, OF) on OPq instructions.
- Evaluates the jXX/cmovXX condition (ifun) against the stored flags and produces cnd for the fetch/PC-select and write-back logic.
- Sits directly after the ALU in the execute stage of the Seq datapath.

Parameters:
- BYPASS, 0: when 1, cnd is evaluated from the flags being written in the same cycle (set_cc=1); when 0, cnd always uses the registered CC.
- WIDTH, 64: ALU result width. SF is bit WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set_cc  input  1  update CC from the ALU this cycle (OPq in execute).
- cc_hold  input  1  suppress CC update (exception status not AOK); overrides set_cc.
- alu_res  input  WIDTH  ALU result, signed.
- alu_overflow  input  1  ALU overflow flag.
- alu_zero  input  1  ALU zero flag.
- ifun  input  4  condition function code.
- zf  output  1  registered zero flag.
- sf  output  1  registered sign flag.
- of  output  1  registered overflow flag.
- cnd  output  1  condition result, combinational.
- ifun_bad  output  1  ifun > 6, combinational.
- cc_upd  output  1  registered pulse: CC was written on the previous edge.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): zf=1, sf=0, of=0, cc_upd=0. Outputs hold these values until the first qualifying edge after deassertion.
- Update condition: upd = set_cc & ~cc_hold.
- On a rising edge with upd=1:
  - zf <= alu_zero
  - sf <= alu_res[WIDTH-1]
  - of <= alu_overflow
  - cc_upd <= 1
- On a rising edge with upd=0: flags hold; cc_upd <= 0.
- Latency: 1 clock from ALU inputs to zf/sf/of.
- Flag source (eZF/eSF/eOF):
  - BYPASS=1 and upd=1: taken from the incoming ALU signals.
  - Otherwise: taken from the registered flags.
- Condition table (cnd):
  - 0 always: 1
  - 1 le: (eSF^eOF)|eZF
  - 2 l: eSF^eOF
  - 3 e: eZF
  - 4 ne: ~eZF
  - 5 ge: ~(eSF^eOF)
  - 6 g: ~(eSF^eOF)&~eZF
  - 7..15: cnd=0, ifun_bad=1
- ifun_bad=0 for ifun 0..6.
- alu_zero is trusted as given; no recomputation from alu_res. Mismatches are the ALU's responsibility.
- Simultaneous set_cc=1 and cc_hold=1: no update, cc_upd=0.
- Reset asserted mid-cycle: flags go to reset values immediately, regardless of set_cc. Deassertion near an edge is handled by the synchronizer upstream.
- Inputs X while upd=0: must not disturb the flags.
- Back-to-back updates: every edge with upd=1 overwrites the flags. There is no accumulation; the last writer wins.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle after flags are 0/1/1 -> zf=1, sf=0, of=0, cc_upd=0 without waiting for a clock edge; ifun=3 -> cnd=1.
- SUB compare: alu_res=0x0, alu_zero=1, alu_overflow=0, set_cc=1, one edge -> zf=1, sf=0, of=0, cc_upd=1 for one cycle. Check ifun=1,3,5 -> cnd=1 and ifun=2,4,6 -> cnd=0.
- Signed overflow: alu_res=0x8000000000000000, alu_overflow=1, alu_zero=0, set_cc=1 -> sf=1, of=1, zf=0. Check ifun=2 (l) -> cnd=0 and ifun=5 (ge) -> cnd=1.
- Hold: flags zf=0/sf=1/of=0; apply set_cc=1, cc_hold=1, alu_zero=1 -> flags unchanged, cc_upd=0. Check ifun=2 -> cnd=1.
- Bypass: with BYPASS=1 and registered zf=0, set_cc=1, alu_zero=1, ifun=3 -> cnd=1 in the same cycle. With BYPASS=0 the same stimulus -> cnd=0 until after the edge.
- Illegal and always: ifun=0 -> cnd=1, ifun_bad=0. ifun=7 and ifun=15 -> cnd=0, ifun_bad=1, flags unaffected.
